// File: rtl/winequality_red_feature_loader.sv
// rtl/winequality_red_feature_loader.sv - serial feature loader and result port for the winequality_redtnn classifier
module winequality_red_feature_loader #(
    parameter int N      = 11,
    parameter int B      = 4,
    parameter int C      = 6,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 feat_valid,
    output logic                 feat_ready,
    input  logic [B-1:0]         feat_data,
    input  logic                 feat_last,
    output logic [N*B-1:0]       inp,
    input  logic [$clog2(C)-1:0] klass,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [$clog2(C)-1:0] res_klass,
    output logic                 res_bad,
    output logic                 frame_err,
    output logic [15:0]          sample_cnt
);

    localparam int CW  = $clog2(C);
    localparam int IW  = $clog2(N);
    localparam int SCW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [IW-1:0]  IDX_LAST  = IW'(N - 1);
    localparam logic [CW:0]    C_LIMIT   = (CW + 1)'(C);
    localparam logic [CW-1:0]  C_MAX     = CW'(C - 1);
    localparam logic [SCW-1:0] SETTLE_LD = SCW'(SETTLE);
    localparam logic [SCW-1:0] SETTLE_END = SCW'(1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [SCW-1:0] settle_cnt;
    logic [15:0]    sample_cnt_q;
    logic           klass_bad;

    // Classifier codes at or above C are not legal classes; flag and clamp them.
    assign klass_bad  = ({1'b0, klass} >= C_LIMIT);

    // Beats are only taken while collecting a frame.
    assign feat_ready = (state == S_LOAD);
    assign sample_cnt = sample_cnt_q;

    // Frame collection, settle timing, result capture and handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LOAD;
            idx          <= '0;
            settle_cnt   <= '0;
            inp          <= '0;
            res_valid    <= 1'b0;
            res_klass    <= '0;
            res_bad      <= 1'b0;
            frame_err    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    if (feat_valid) begin
                        // First beat drifts up to the MSB nibble as later beats arrive.
                        inp <= {inp[N*B-B-1:0], feat_data};
                        if (idx == IDX_LAST && feat_last) begin
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LD;
                            idx        <= '0;
                        end else if (idx == IDX_LAST || feat_last) begin
                            // Wrong length: drop the frame; the bad beat is consumed.
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        res_klass <= klass_bad ? C_MAX : klass;
                        res_bad   <= klass_bad;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        settle_cnt <= settle_cnt - SCW'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid    <= 1'b0;
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                        state        <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winequality_red_feature_loader.sv
// tb/tb_winequality_red_feature_loader.sv - directed bench for winequality_red_feature_loader
module tb_winequality_red_feature_loader;

    logic        clk;
    logic        rst_n;
    logic        feat_valid;
    logic        feat_ready;
    logic [3:0]  feat_data;
    logic        feat_last;
    logic [43:0] inp;
    logic [2:0]  klass;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_klass;
    logic        res_bad;
    logic        frame_err;
    logic [15:0] sample_cnt;

    int checks;
    int errors;
    int exp_cnt;

    winequality_red_feature_loader #(
        .N(11), .B(4), .C(6), .SETTLE(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .inp        (inp),
        .klass      (klass),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_klass  (res_klass),
        .res_bad    (res_bad),
        .frame_err  (frame_err),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive nb beats of v starting at the MSB nibble; feat_last on beat index last_at.
    task automatic send(input logic [43:0] v, input int last_at, input int nb);
        for (int i = 0; i < nb; i++) begin
            feat_valid = 1'b1;
            feat_data  = v[43-4*i -: 4];
            feat_last  = (i == last_at);
            @(negedge clk);
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Full good frame with res_ready high; checks the result and the feat_ready gap.
    task automatic run_frame(input logic [43:0] v, input logic [2:0] k,
                             input logic [2:0] ek, input logic eb);
        int lows;
        logic seen;
        klass     = k;
        res_ready = 1'b1;
        send(v, 10, 11);
        lows = 0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !feat_ready; t++) begin
            if (res_valid) begin
                seen = 1'b1;
                check("frame_res_klass", 64'(res_klass), 64'(ek));
                check("frame_res_bad", 64'(res_bad), 64'(eb));
                check("frame_inp", 64'(inp), 64'(v));
            end
            lows++;
            @(negedge clk);
        end
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        check("frame_res_seen", 64'(seen), 64'd1);
        check("frame_ready_low_cycles", 64'(lows), 64'd2);
        check("frame_sample_cnt", 64'(sample_cnt), 64'(exp_cnt));
        res_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inp"}, 64'(inp), 64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_klass"}, 64'(res_klass), 64'd0);
        check({tag, "_res_bad"}, 64'(res_bad), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        check({tag, "_feat_ready"}, 64'(feat_ready), 64'd1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_cnt    = 0;
        rst_n      = 1'b0;
        feat_valid = 1'b0;
        feat_data  = 4'h0;
        feat_last  = 1'b0;
        klass      = 3'd0;
        res_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_rst");

        // Nominal sample with explicit latency checks.
        klass = 3'd3;
        send(44'h46012229a22, 10, 11);
        check("nom_settle_res_valid", 64'(res_valid), 64'd0);
        check("nom_settle_feat_ready", 64'(feat_ready), 64'd0);
        check("nom_settle_inp", 64'(inp), 64'h46012229a22);
        @(negedge clk);
        check("nom_out_res_valid", 64'(res_valid), 64'd1);
        check("nom_out_res_klass", 64'(res_klass), 64'd3);
        check("nom_out_res_bad", 64'(res_bad), 64'd0);
        check("nom_out_inp", 64'(inp), 64'h46012229a22);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt = 1;
        check("nom_hand_res_valid", 64'(res_valid), 64'd0);
        check("nom_hand_feat_ready", 64'(feat_ready), 64'd1);
        check("nom_hand_sample_cnt", 64'(sample_cnt), 64'd1);

        // Back-to-back samples.
        run_frame(44'h58022538633, 3'd5, 3'd5, 1'b0);
        run_frame(44'h92912439523, 3'd2, 3'd2, 1'b0);

        // Backpressure: result held, beats offered but refused.
        klass = 3'd4;
        send(44'h3a5c0f1e2d7, 10, 11);
        @(negedge clk);
        klass      = 3'd1;
        feat_valid = 1'b1;
        feat_data  = 4'hf;
        feat_last  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("bp_res_valid", 64'(res_valid), 64'd1);
            check("bp_res_klass", 64'(res_klass), 64'd4);
            check("bp_inp", 64'(inp), 64'h3a5c0f1e2d7);
            check("bp_feat_ready", 64'(feat_ready), 64'd0);
            check("bp_frame_err", 64'(frame_err), 64'd0);
            @(negedge clk);
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt++;
        check("bp_rel_res_valid", 64'(res_valid), 64'd0);
        check("bp_rel_sample_cnt", 64'(sample_cnt), 64'(exp_cnt));
        @(negedge clk);
        check("bp_single_res_valid", 64'(res_valid), 64'd0);
        check("bp_single_sample_cnt", 64'(sample_cnt), 64'(exp_cnt));

        // Early feat_last on beat 5.
        send(44'h11111111111, 4, 5);
        check("early_frame_err", 64'(frame_err), 64'd1);
        @(negedge clk);
        check("early_frame_err_drop", 64'(frame_err), 64'd0);
        check("early_res_valid", 64'(res_valid), 64'd0);
        check("early_feat_ready", 64'(feat_ready), 64'd1);
        run_frame(44'h57122338733, 3'd1, 3'd1, 1'b0);

        // Eleven beats with no feat_last.
        send(44'h22222222222, -1, 11);
        check("nolast_frame_err", 64'(frame_err), 64'd1);
        @(negedge clk);
        check("nolast_frame_err_drop", 64'(frame_err), 64'd0);
        check("nolast_res_valid", 64'(res_valid), 64'd0);
        check("nolast_sample_cnt", 64'(sample_cnt), 64'(exp_cnt));
        run_frame(44'h57122338733, 3'd0, 3'd0, 1'b0);

        // Out-of-range class code is clamped and flagged.
        run_frame(44'h0123456789a, 3'd7, 3'd5, 1'b1);

        // Asynchronous reset part-way through a frame.
        send(44'hfedcba98765, -1, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        check_reset_values("after_async_rst");
        run_frame(44'h46012229a22, 3'd3, 3'd3, 1'b0);

        // Counter wrap from a preloaded 16'hFFFF.
        force dut.sample_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.sample_cnt_q;
        @(negedge clk);
        check("wrap_preload", 64'(sample_cnt), 64'hFFFF);
        exp_cnt = 16'hFFFF;
        run_frame(44'h46012229a22, 3'd2, 3'd2, 1'b0);
        check("wrap_zero", 64'(sample_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
